mm_quote_engine: RTL and testbench
==================================

Name: mm_quote_engine

Overview:
- Parametrised next-generation market-making decision core.
- Accepts a stream of price ticks over a valid/ready handshake and keeps previous price and tumbling-window min/max.
- Derives a bid/ask band around a runtime reservation price, detects trend and risk, and enforces a signed position limit.
- Emits at most one buy/sell order per tick over a valid/ready handshake, then enters a cooldown. Sits between the feed decoder and the order gateway.

Parameters:
- PRICE_W, 16: price width in bits, unsigned.
- POS_W, 8: position counter width, two's complement.
- POS_LIMIT, 4: maximum absolute position; must be less than 2^(POS_W-1).
- WINDOW, 32: samples per tumbling min/max window; must be at least 2.
- COOLDOWN_CYC, 4: idle cycles after each order handshake; 0 means no cooldown.
- SKEW_STEP, 2: price skew per unit of position (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  reset
- px_valid  in  1  tick valid
- px_ready  out  1  engine can accept a tick
- px_data  in  PRICE_W  tick price
- cfg_reservation  in  PRICE_W  reservation price
- cfg_spread  in  PRICE_W  half-spread
- cfg_trend_th  in  PRICE_W  trend threshold
- cfg_risk_th  in  PRICE_W  risk band half-width
- ord_valid  out  1  order valid
- ord_ready  in  1  gateway accepts order
- ord_side  out  1  0 = buy, 1 = sell
- ord_price  out  PRICE_W  order price (the triggering tick)
- position  out  POS_W  signed net position
- risk_halt  out  1  last evaluated tick outside the risk band
- win_min  out  PRICE_W  min of last completed window
- win_max  out  PRICE_W  max of last completed window
- win_valid  out  1  one-cycle pulse when win_min/win_max update

Behaviour:
- Clock clk; reset reset, asynchronous, active-high.
- Reset values: state IDLE, px_ready 1, ord_valid 0, ord_side 0, ord_price 0, position 0, risk_halt 0, win_min 0, win_max 0, win_valid 0. Internal prev_valid 0, window count 0.
- Reset mid-operation drops any pending order and clears position and all state.
- FSM states: IDLE, EVAL, ISSUE, COOLDOWN. px_ready = (state == IDLE).
  - IDLE: on px_valid && px_ready at cycle t, register px_data into cur and move to EVAL.
  - EVAL (t+1): compute the decision from cur, prev, prev_valid and cfg_*; register risk_halt; set prev <= cur and prev_valid <= 1.
    - If buy or sell: go to ISSUE with ord_valid = 1 at t+2, ord_price = cur.
    - Otherwise: go to IDLE (px_ready high at t+2).
  - ISSUE: hold ord_valid, ord_side and ord_price stable until ord_ready.
    - On handshake: buy increments position by 1, sell decrements by 1, ord_valid drops the next cycle.
    - Then go to COOLDOWN, or to IDLE if COOLDOWN_CYC == 0.
  - COOLDOWN: count COOLDOWN_CYC cycles, then IDLE. Ticks are back-pressured, never dropped.
- Arithmetic: use PRICE_W+1-bit intermediates and saturate at 0 and 2^PRICE_W-1.
  - bid = sat(res - cfg_spread); ask = sat(res + cfg_spread).
  - up = prev_valid && cur > sat(prev + cfg_trend_th).
  - down = prev_valid && cur < sat(prev - cfg_trend_th).
  - risk = cur < sat(res - cfg_risk_th) || cur > sat(res + cfg_risk_th).
- Decision:
  - buy = cur < bid && up && !risk && position < POS_LIMIT.
  - sell = cur > ask && down && !risk && position > -POS_LIMIT.
  - buy and sell are mutually exclusive by construction; if both were ever true, buy wins.
- The first tick after reset never trades (prev_valid = 0).
- Window:
  - The running min/max is seeded by the first tick of each window and updated on each accepted tick.
  - On the WINDOW-th tick (counter wrap), win_min/win_max load the final values including that tick, and win_valid pulses one cycle after acceptance.
  - The counter wraps to 0 and the next tick reseeds.

Optional Feature:
- Macro: MM_QUOTE_SKEW_EN.
- Defined: res = sat(cfg_reservation - position*SKEW_STEP), signed product, saturating. Long positions lower quotes; short positions raise them.
- Undefined: res = cfg_reservation, SKEW_STEP unused, and no multiplier is synthesised.

Decomposition:
- Package mm_pkg holds:
  - state enum (IDLE, EVAL, ISSUE, COOLDOWN);
  - side enum (SIDE_BUY = 0, SIDE_SELL = 1);
  - the saturating add/sub functions, parametrised by width through a W+1 intermediate.
- Sub-module mm_window_minmax (PRICE_W, WINDOW) takes a sample strobe and data, and owns the counter, running min/max, win_min/win_max and win_valid.

Test Plan (PRICE_W=8, res=0x80, spread=0x10, trend_th=0x08, risk_th=0x40, POS_LIMIT=2, COOLDOWN_CYC=3, skew off):
- Reset, then ticks 0x60 then 0x6A -> no order on 0x60 (first tick). On 0x6A (> 0x60+8, < 0x70): buy with ord_price 0x6A two cycles after acceptance, position 1 after handshake, px_ready low 3 cycles.
- Hold ord_ready low 5 cycles during a buy -> ord_valid and ord_price stay stable, px_ready stays 0, position changes only on the handshake cycle.
- Three qualifying buys -> position reaches 2, the third qualifying tick yields no order.
- Ticks 0xFF then 0xE0 -> down trend but risk (0xE0 > 0xC0): risk_halt 1, no sell. Tick 0x00 saturates bid/threshold math without wrap.
- WINDOW=4, ticks 5,9,2,7 -> win_valid pulse with win_min 2, win_max 9. Next window 8,8,8,8 -> min = max = 8.
- Reset asserted while ord_valid=1 -> ord_valid 0 and position 0 asynchronously; next tick treated as first tick.

Source files
------------

// File: rtl/mm_pkg.sv
// mm_pkg: shared state/side encodings and saturating price arithmetic for the quote engine
package mm_pkg;

    typedef enum logic [1:0] {IDLE, EVAL, ISSUE, COOLDOWN} state_e;
    typedef enum logic {SIDE_BUY = 1'b0, SIDE_SELL = 1'b1} side_e;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int unsigned w);
        logic [32:0] s;
        logic [32:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (s > lim) ? lim[31:0] : s[31:0];
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? a - b : 32'd0;
    endfunction

endpackage

// File: rtl/mm_window_minmax.sv
// mm_window_minmax: tumbling-window running min/max, publishing the result once per WINDOW samples
module mm_window_minmax
    import mm_pkg::*;
#(
    parameter int PRICE_W = 16,
    parameter int WINDOW  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_i,
    input  logic [PRICE_W-1:0] data_i,
    output logic [PRICE_W-1:0] win_min_o,
    output logic [PRICE_W-1:0] win_max_o,
    output logic               win_valid_o
);

    localparam int CW = $clog2(WINDOW);
    localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

    logic [CW-1:0]      cnt_q;
    logic [PRICE_W-1:0] run_min_q, run_max_q, win_min_q, win_max_q;
    logic [PRICE_W-1:0] min_d, max_d;
    logic               win_valid_q;

    // first sample of a window reseeds, later samples fold into the running extremes
    always_comb begin
        min_d = (cnt_q == '0 || data_i < run_min_q) ? data_i : run_min_q;
        max_d = (cnt_q == '0 || data_i > run_max_q) ? data_i : run_max_q;
    end

    // counter, running extremes and the published window result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            run_min_q   <= '0;
            run_max_q   <= '0;
            win_min_q   <= '0;
            win_max_q   <= '0;
            win_valid_q <= 1'b0;
        end else begin
            win_valid_q <= sample_i && cnt_q == LAST;
            if (sample_i) begin
                run_min_q <= min_d;
                run_max_q <= max_d;
                cnt_q     <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    win_min_q <= min_d;
                    win_max_q <= max_d;
                end
            end
        end
    end

    assign win_min_o   = win_min_q;
    assign win_max_o   = win_max_q;
    assign win_valid_o = win_valid_q;

endmodule

// File: rtl/mm_quote_engine.sv
// mm_quote_engine: tick-driven buy/sell decision core with position limit and cooldown; MM_QUOTE_SKEW_EN enables position skew of the reservation price
module mm_quote_engine
    import mm_pkg::*;
#(
    parameter int PRICE_W      = 16,
    parameter int POS_W        = 8,
    parameter int POS_LIMIT    = 4,
    parameter int WINDOW       = 32,
    parameter int COOLDOWN_CYC = 4,
    parameter int SKEW_STEP    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               px_valid,
    output logic               px_ready,
    input  logic [PRICE_W-1:0] px_data,
    input  logic [PRICE_W-1:0] cfg_reservation,
    input  logic [PRICE_W-1:0] cfg_spread,
    input  logic [PRICE_W-1:0] cfg_trend_th,
    input  logic [PRICE_W-1:0] cfg_risk_th,
    output logic               ord_valid,
    input  logic               ord_ready,
    output logic               ord_side,
    output logic [PRICE_W-1:0] ord_price,
    output logic [POS_W-1:0]   position,
    output logic               risk_halt,
    output logic [PRICE_W-1:0] win_min,
    output logic [PRICE_W-1:0] win_max,
    output logic               win_valid
);

    localparam int CDW = (COOLDOWN_CYC > 2) ? $clog2(COOLDOWN_CYC) : 1;
    localparam logic [CDW-1:0] CD_LAST = CDW'((COOLDOWN_CYC > 0) ? COOLDOWN_CYC - 1 : 0);
    localparam logic signed [POS_W-1:0] LIM = POS_W'(POS_LIMIT);
    localparam logic signed [POS_W-1:0] ONE = POS_W'(1);

    state_e                    state_q;
    side_e                     ord_side_q;
    logic [PRICE_W-1:0]        cur_q, prev_q, ord_price_q;
    logic                      prev_valid_q, risk_halt_q, ord_valid_q;
    logic signed [POS_W-1:0]   position_q;
    logic [CDW-1:0]            cd_q;
    logic [31:0]               cur_w, prev_w, res_w, bid_w, ask_w, th_w, rk_w;
    logic                      up, down, risk, buy, sell;

    assign cur_w  = 32'(cur_q);
    assign prev_w = 32'(prev_q);
    assign th_w   = 32'(cfg_trend_th);
    assign rk_w   = 32'(cfg_risk_th);

`ifdef MM_QUOTE_SKEW_EN
    logic signed [31:0] skew_w;
    assign skew_w = 32'(position_q) * 32'(SKEW_STEP);
    assign res_w  = skew_w[31] ? sat_add(32'(cfg_reservation), 32'(-skew_w), PRICE_W)
                               : sat_sub(32'(cfg_reservation), 32'(skew_w));
`else
    assign res_w  = 32'(cfg_reservation);
`endif

    assign bid_w = sat_sub(res_w, 32'(cfg_spread));
    assign ask_w = sat_add(res_w, 32'(cfg_spread), PRICE_W);
    assign up    = prev_valid_q && cur_w > sat_add(prev_w, th_w, PRICE_W);
    assign down  = prev_valid_q && cur_w < sat_sub(prev_w, th_w);
    assign risk  = cur_w < sat_sub(res_w, rk_w) || cur_w > sat_add(res_w, rk_w, PRICE_W);
    assign buy   = cur_w < bid_w && up && !risk && position_q < LIM;
    assign sell  = cur_w > ask_w && down && !risk && position_q > -LIM;

    // tick capture, evaluation, order handshake and cooldown sequencing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cur_q        <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            risk_halt_q  <= 1'b0;
            ord_valid_q  <= 1'b0;
            ord_side_q   <= SIDE_BUY;
            ord_price_q  <= '0;
            position_q   <= '0;
            cd_q         <= '0;
        end else begin
            case (state_q)
                IDLE: if (px_valid) begin
                    cur_q   <= px_data;
                    state_q <= EVAL;
                end
                EVAL: begin
                    risk_halt_q  <= risk;
                    prev_q       <= cur_q;
                    prev_valid_q <= 1'b1;
                    state_q      <= (buy || sell) ? ISSUE : IDLE;
                    if (buy || sell) begin
                        ord_valid_q <= 1'b1;
                        ord_side_q  <= buy ? SIDE_BUY : SIDE_SELL;
                        ord_price_q <= cur_q;
                    end
                end
                ISSUE: if (ord_ready) begin
                    ord_valid_q <= 1'b0;
                    position_q  <= (ord_side_q == SIDE_BUY) ? position_q + ONE : position_q - ONE;
                    cd_q        <= '0;
                    state_q     <= (COOLDOWN_CYC == 0) ? IDLE : COOLDOWN;
                end
                COOLDOWN: begin
                    cd_q <= cd_q + 1'b1;
                    if (cd_q == CD_LAST) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    mm_window_minmax #(.PRICE_W(PRICE_W), .WINDOW(WINDOW)) u_win (
        .clk        (clk),
        .reset      (reset),
        .sample_i   (px_valid && px_ready),
        .data_i     (px_data),
        .win_min_o  (win_min),
        .win_max_o  (win_max),
        .win_valid_o(win_valid)
    );

    assign px_ready  = (state_q == IDLE);
    assign ord_valid = ord_valid_q;
    assign ord_side  = ord_side_q;
    assign ord_price = ord_price_q;
    assign position  = position_q;
    assign risk_halt = risk_halt_q;

endmodule

// File: tb/tb_mm_quote_engine.sv
// tb_mm_quote_engine: directed vector table plus hand sequences for hold, reset and window behaviour
module tb_mm_quote_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       px_valid = 1'b0, ord_ready = 1'b0;
    logic [7:0] px_data = '0;
    logic [7:0] cfg_reservation = 8'h80, cfg_spread = 8'h10, cfg_trend_th = 8'h08, cfg_risk_th = 8'h40;
    logic       px_ready, ord_valid, ord_side, risk_halt, win_valid;
    logic [7:0] ord_price, position, win_min, win_max;

    int n_chk = 0, n_pass = 0;
    logic       wv_s;
    logic [7:0] wmin_s, wmax_s;

    typedef struct {
        logic [7:0] px, sp, rk;
        int         hold;
        logic       ord, side;
        int         pos;
        logic       risk;
    } vec_t;
    vec_t v[22];

    mm_quote_engine #(.PRICE_W(8), .POS_W(8), .POS_LIMIT(2), .WINDOW(4), .COOLDOWN_CYC(3), .SKEW_STEP(2)) dut (
        .clk(clk), .reset(reset), .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data),
        .cfg_reservation(cfg_reservation), .cfg_spread(cfg_spread), .cfg_trend_th(cfg_trend_th),
        .cfg_risk_th(cfg_risk_th), .ord_valid(ord_valid), .ord_ready(ord_ready), .ord_side(ord_side),
        .ord_price(ord_price), .position(position), .risk_halt(risk_halt), .win_min(win_min),
        .win_max(win_max), .win_valid(win_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] px, input int hold, input logic exp_ord, input logic exp_side,
                        input int exp_pos, input logic exp_risk, input string tag);
        int k = 0;
        int pos0;
        int busy = 0;
        while (!px_ready && k < 20) begin step(); k++; end
        if (!px_ready) begin chk($sformatf("%s ready_timeout", tag), 0, 1); return; end
        px_valid = 1'b1;
        px_data  = px;
        step();
        px_valid = 1'b0;
        wv_s = win_valid; wmin_s = win_min; wmax_s = win_max;
        pos0 = $signed(position);
        step();
        chk($sformatf("%s ord_valid", tag), int'(ord_valid), int'(exp_ord));
        chk($sformatf("%s risk_halt", tag), int'(risk_halt), int'(exp_risk));
        if (exp_ord && ord_valid) begin
            chk($sformatf("%s side", tag), int'(ord_side), int'(exp_side));
            chk($sformatf("%s price", tag), int'(ord_price), int'(px));
            for (int i = 0; i < hold; i++) begin
                step();
                chk($sformatf("%s hold%0d", tag, i),
                    int'(ord_valid && ord_price == px && !px_ready && $signed(position) == pos0), 1);
            end
            ord_ready = 1'b1;
            step();
            ord_ready = 1'b0;
            chk($sformatf("%s position", tag), $signed(position), exp_pos);
            chk($sformatf("%s ord_drop", tag), int'(ord_valid), 0);
            for (int i = 0; i < 3; i++) begin busy += int'(!px_ready); step(); end
            chk($sformatf("%s cooldown_busy", tag), busy, 3);
            chk($sformatf("%s cooldown_end", tag), int'(px_ready), 1);
        end else begin
            if (ord_valid) begin ord_ready = 1'b1; step(); ord_ready = 1'b0; end
            chk($sformatf("%s position", tag), $signed(position), exp_pos);
            chk($sformatf("%s idle", tag), int'(px_ready), 1);
        end
    endtask

    initial begin
        v[0]  = '{8'h60, 8'h10, 8'h40, 0, 1'b0, 1'b0,  0, 1'b0};
        v[1]  = '{8'h6A, 8'h10, 8'h40, 5, 1'b1, 1'b0,  1, 1'b0};
        v[2]  = '{8'h50, 8'h10, 8'h40, 0, 1'b0, 1'b0,  1, 1'b0};
        v[3]  = '{8'h5A, 8'h10, 8'h40, 0, 1'b1, 1'b0,  2, 1'b0};
        v[4]  = '{8'h50, 8'h10, 8'h40, 0, 1'b0, 1'b0,  2, 1'b0};
        v[5]  = '{8'h5A, 8'h10, 8'h40, 0, 1'b0, 1'b0,  2, 1'b0};
        v[6]  = '{8'hFF, 8'h10, 8'h40, 0, 1'b0, 1'b0,  2, 1'b1};
        v[7]  = '{8'hE0, 8'h10, 8'h40, 0, 1'b0, 1'b0,  2, 1'b1};
        v[8]  = '{8'h00, 8'h10, 8'h40, 0, 1'b0, 1'b0,  2, 1'b1};
        v[9]  = '{8'hF0, 8'h10, 8'h90, 0, 1'b0, 1'b0,  2, 1'b0};
        v[10] = '{8'hE0, 8'h10, 8'h90, 0, 1'b1, 1'b1,  1, 1'b0};
        v[11] = '{8'h10, 8'hA0, 8'h90, 0, 1'b0, 1'b0,  1, 1'b0};
        v[12] = '{8'h20, 8'hA0, 8'h90, 0, 1'b0, 1'b0,  1, 1'b0};
        v[13] = '{8'h18, 8'h10, 8'h40, 0, 1'b0, 1'b0,  1, 1'b1};
        v[14] = '{8'hA0, 8'h10, 8'h40, 0, 1'b0, 1'b0,  1, 1'b0};
        v[15] = '{8'h96, 8'h10, 8'h40, 0, 1'b1, 1'b1,  0, 1'b0};
        v[16] = '{8'hA0, 8'h10, 8'h40, 0, 1'b0, 1'b0,  0, 1'b0};
        v[17] = '{8'h96, 8'h10, 8'h40, 0, 1'b1, 1'b1, -1, 1'b0};
        v[18] = '{8'hA0, 8'h10, 8'h40, 0, 1'b0, 1'b0, -1, 1'b0};
        v[19] = '{8'h96, 8'h10, 8'h40, 0, 1'b1, 1'b1, -2, 1'b0};
        v[20] = '{8'hA0, 8'h10, 8'h40, 0, 1'b0, 1'b0, -2, 1'b0};
        v[21] = '{8'h96, 8'h10, 8'h40, 0, 1'b0, 1'b0, -2, 1'b0};

        step(); step();
        reset = 1'b0;
        chk("rst px_ready", int'(px_ready), 1);
        chk("rst ord_valid", int'(ord_valid), 0);
        chk("rst ord_side", int'(ord_side), 0);
        chk("rst ord_price", int'(ord_price), 0);
        chk("rst position", int'(position), 0);
        chk("rst risk_halt", int'(risk_halt), 0);
        chk("rst win", int'({win_min, win_max, win_valid}), 0);

        for (int i = 0; i < 22; i++) begin
            cfg_spread  = v[i].sp;
            cfg_risk_th = v[i].rk;
            send(v[i].px, v[i].hold, v[i].ord, v[i].side, v[i].pos, v[i].risk, $sformatf("vec%0d", i));
        end

        send(8'h60, 0, 1'b0, 1'b0, -2, 1'b0, "rst_pre");
        px_valid = 1'b1; px_data = 8'h6A;
        step();
        px_valid = 1'b0;
        step();
        chk("rst_mid ord_valid_before", int'(ord_valid), 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid ord_valid", int'(ord_valid), 0);
        chk("rst_mid position", int'(position), 0);
        chk("rst_mid px_ready", int'(px_ready), 1);
        step();
        reset = 1'b0;
        send(8'h6A, 0, 1'b0, 1'b0, 0, 1'b0, "first_after_rst");

        reset = 1'b1;
        step();
        reset = 1'b0;
        send(8'd5, 0, 1'b0, 1'b0, 0, 1'b1, "w0");
        chk("w0 win_valid", int'(wv_s), 0);
        send(8'd9, 0, 1'b0, 1'b0, 0, 1'b1, "w1");
        send(8'd2, 0, 1'b0, 1'b0, 0, 1'b1, "w2");
        chk("w2 win_valid", int'(wv_s), 0);
        send(8'd7, 0, 1'b0, 1'b0, 0, 1'b1, "w3");
        chk("w3 win_valid", int'(wv_s), 1);
        chk("w3 win_min", int'(wmin_s), 2);
        chk("w3 win_max", int'(wmax_s), 9);
        chk("w3 pulse_drop", int'(win_valid), 0);
        send(8'd8, 0, 1'b0, 1'b0, 0, 1'b1, "w4");
        chk("w4 held_min", int'(wmin_s), 2);
        send(8'd8, 0, 1'b0, 1'b0, 0, 1'b1, "w5");
        send(8'd8, 0, 1'b0, 1'b0, 0, 1'b1, "w6");
        send(8'd8, 0, 1'b0, 1'b0, 0, 1'b1, "w7");
        chk("w7 win_valid", int'(wv_s), 1);
        chk("w7 win_min", int'(wmin_s), 8);
        chk("w7 win_max", int'(wmax_s), 8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
